// File: rtl/frame_buffer_writer.sv
// Frame buffer write side: packs an R,G,B byte stream into 24-bit pixels and
// drives the frame RAM write port with a running raster address.
module frame_buffer_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_R = 3'd1;
  localparam logic [2:0] LOAD_G = 3'd2;
  localparam logic [2:0] LOAD_B = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        r_q, r_d, g_q, g_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              loading, accept;

  // A restart pulse takes priority over the stream, so no byte is consumed with it.
  assign loading    = (state_q == LOAD_R) || (state_q == LOAD_G) || (state_q == LOAD_B);
  assign byte_ready = loading && !start;
  assign busy       = loading || (state_q == DONE);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    g_d       = g_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = (state_q == DONE);
    if (start) begin
      state_d = LOAD_R;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_R: if (accept) begin
          r_d     = byte_data;
          state_d = LOAD_G;
        end
        LOAD_G: if (accept) begin
          g_d     = byte_data;
          state_d = LOAD_B;
        end
        LOAD_B: if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = {r_q, g_q, byte_data};
          if (cnt_q == LAST_PIX) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD_R;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      g_q       <= g_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench: a 4x2 instance for directed cases and a 64x48 instance
// streamed end to end for address/count/frame_done coverage.
module tb_frame_buffer_writer;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, wr_en, busy, frame_done;
  logic [18:0] wr_address;
  logic [23:0] wr_data;

  logic        b_start, b_valid;
  logic [7:0]  b_data;
  logic        b_ready, b_wr_en, b_busy, b_frame_done;
  logic [11:0] b_wr_address;
  logic [23:0] b_wr_data;

  always #5 clk = ~clk;

  frame_buffer_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_address(wr_address), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done));

  frame_buffer_writer #(.H_ACTIVE(64), .V_ACTIVE(48), .ADDR_W(12)) dut_big (
    .clk(clk), .rst(rst), .start(b_start), .byte_valid(b_valid),
    .byte_data(b_data), .byte_ready(b_ready), .wr_en(b_wr_en),
    .wr_address(b_wr_address), .wr_data(b_wr_data), .busy(b_busy),
    .frame_done(b_frame_done));

  int checks = 0;
  int errors = 0;
  logic [42:0] exp_q[$];
  int          done_seen = 0;
  logic        prev_wr_en = 1'b0;
  logic [18:0] prev_addr = '0;
  int          b_wr_cnt = 0;
  int          b_done = 0;
  logic [11:0] b_last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Small-DUT monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_address, wr_data);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        chk("wr_address", 32'(wr_address), 32'(e[42:24]));
        chk("wr_data", 32'(wr_data), 32'(e[23:0]));
      end
    end
    if (frame_done) begin
      done_seen++;
      chk("frame_done_after_last_write", {31'd0, prev_wr_en && prev_addr == 19'd7}, 32'd1);
    end
    prev_wr_en = wr_en;
    prev_addr  = wr_address;
  end

  always @(negedge clk) begin
    if (b_wr_en) begin
      logic [23:0] e;
      e = {8'(3*b_wr_cnt), 8'(3*b_wr_cnt+1), 8'(3*b_wr_cnt+2)};
      chk("big_addr", 32'(b_wr_address), 32'(b_wr_cnt));
      chk("big_data", 32'(b_wr_data), 32'(e));
      b_last_addr = b_wr_address;
      b_wr_cnt++;
    end
    if (b_frame_done) b_done++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    logic ok;
    repeat (gap) tick();
    byte_valid = 1'b1; byte_data = d; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1; ok = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, required accept", d);
    end
  endtask

  task automatic send_pixel(input logic [7:0] r, g, b, input int gap);
    send_byte(r, gap); send_byte(g, gap); send_byte(b, gap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_data = 8'h5A;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr_address", 32'(wr_address), 32'd0);
    end
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    byte_valid = 1'b0;

    // single pixel, back-to-back
    pulse_start();
    chk("load_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({19'd0, 24'h123456});
    send_pixel(8'h12, 8'h34, 8'h56, 0);
    chk("write_latency", {31'd0, wr_en}, 32'd1);
    repeat (3) tick();

    // stalled source
    pulse_start();
    exp_q.push_back({19'd0, 24'h123456});
    send_pixel(8'h12, 8'h34, 8'h56, 2);
    chk("stall_write_latency", {31'd0, wr_en}, 32'd1);
    repeat (3) tick();

    // restart mid-pixel; the byte offered with start must be refused
    pulse_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hCC;
    #1 chk("ready_low_on_start", {31'd0, byte_ready}, 32'd0);
    tick(); start = 1'b0; byte_valid = 1'b0;
    exp_q.push_back({19'd0, 24'h010203});
    send_pixel(8'h01, 8'h02, 8'h03, 0);
    repeat (3) tick();

    // full 4x2 frame
    pulse_start();
    for (int p = 0; p < 8; p++) begin
      logic [7:0] r, g, b;
      r = 8'(16*p + 1); g = 8'(16*p + 2); b = 8'(16*p + 3);
      exp_q.push_back({19'(p), r, g, b});
      send_pixel(r, g, b, 0);
    end
    chk("last_write_en", {31'd0, wr_en}, 32'd1);
    chk("done_state_ready", {31'd0, byte_ready}, 32'd0);
    chk("done_state_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("after_done_busy", {31'd0, busy}, 32'd0);
    byte_valid = 1'b1; byte_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      #1 chk("byte25_not_accepted", {31'd0, byte_ready}, 32'd0);
      tick();
    end
    byte_valid = 1'b0;
    chk("frame_done_single", {31'd0, frame_done}, 32'd0);

    // reset in the middle of a pixel: outputs clear at once, no write issues
    pulse_start();
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    rst = 1'b1;
    #1 chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
    tick(); rst = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h99;
    repeat (3) tick();
    byte_valid = 1'b0;

    // 64x48 frame streamed at one byte per cycle
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k < 9216; k++) begin
      logic ok;
      b_valid = 1'b1; b_data = 8'(k); ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        #1; ok = b_ready;
        tick();
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL big_send_timeout: byte %0d not accepted", k);
        break;
      end
    end
    b_valid = 1'b0;
    repeat (4) tick();
    chk("big_write_count", 32'(b_wr_cnt), 32'd3072);
    chk("big_last_addr", 32'(b_last_addr), 32'd3071);
    chk("big_last_data", 32'(b_wr_data), 32'hFDFEFF);
    chk("big_frame_done_count", 32'(b_done), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("small_frame_done_count", 32'(done_seen), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
